// File: rtl/spike_packet_router.sv
// spike_packet_router
// Ingress stage in front of the tick scheduler. Each accepted spike event has
// its relative axonal delay turned into an absolute 4-bit delivery tick. The
// packet is then buffered in a FIFO and presented on a registered output stage
// with a valid/ready handshake. Packets whose delivery tick equals the
// scheduler's current tick are dropped. This covers both a FIFO head and a
// packet already waiting in the output stage.
//
// Ports
//   clk_i                 system clock, all logic on posedge
//   rst_i                 synchronous active-high reset
//   in_valid_i/in_ready_o ingress handshake (in_ready_o = !full, registered)
//   in_axon_i/in_delay_i/in_debug_i  event fields
//   current_tick_i        scheduler's current tick pointer
//   flush_i               discard all buffered packets
//   spike_packet_o        {delivery_tick[3:0], axon[7:0], debug[1:0]}
//   spike_packet_valid_o/spike_packet_ready_i  egress handshake
//   fifo_level_o          FIFO occupancy (output stage excluded)
//   reject_count_o        saturating count of delay < MIN_DELAY events
//   stale_count_o         saturating count of stale drops
//   error_o               sticky drop flag, cleared only by reset
//
// Build option: SPIKE_ROUTER_STATS_EN enables the two drop counters. When it
// is not defined, both counters read as zero and carry no registers.
//
// Output stage states
//   state    | meaning
//   S_EMPTY  | no packet presented, valid low
//   S_LOADED | packet presented, valid high
module spike_packet_router #(
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_DELAY  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [7:0]                    in_axon_i,
    input  logic [3:0]                    in_delay_i,
    input  logic [1:0]                    in_debug_i,
    input  logic [3:0]                    current_tick_i,
    input  logic                          flush_i,
    output logic [13:0]                   spike_packet_o,
    output logic                          spike_packet_valid_o,
    input  logic                          spike_packet_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [CNT_W-1:0]              reject_count_o,
    output logic [CNT_W-1:0]              stale_count_o,
    output logic                          error_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [3:0]    MIN_D   = 4'(MIN_DELAY);

    typedef enum logic {S_EMPTY, S_LOADED} out_state_e;

    out_state_e    state_q;
    logic [13:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic [13:0]   pkt_q;
    logic          in_ready_q;
    logic          error_q;

    logic          accept, push, reject;
    logic [3:0]    deliv_tick;
    logic [13:0]   head;
    logic          fifo_nempty, head_stale;
    logic          fire, out_stale, can_load, pop;
    logic          head_drop, head_load, stale_evt;

    // A flush cycle swallows any accept, so nothing gets pushed or counted.
    assign accept     = in_valid_i && in_ready_q && !flush_i;
    assign push       = accept && (in_delay_i >= MIN_D);
    assign reject     = accept && (in_delay_i < MIN_D);
    assign deliv_tick = current_tick_i + in_delay_i;

    assign head        = mem_q[rd_ptr_q];
    assign fifo_nempty = (count_q != '0);
    assign head_stale  = (head[13:10] == current_tick_i);

    // A held packet that has gone stale is withdrawn. Nothing is reloaded on
    // that edge, so the FIFO head stays in place for the next cycle.
    assign fire      = (state_q == S_LOADED) && spike_packet_ready_i;
    assign out_stale = (state_q == S_LOADED) && !spike_packet_ready_i &&
                       (pkt_q[13:10] == current_tick_i);
    assign can_load  = (state_q == S_EMPTY) || fire;
    assign pop       = can_load && fifo_nempty;
    assign head_drop = pop && head_stale;
    assign head_load = pop && !head_stale;
    assign stale_evt = (head_drop || out_stale) && !flush_i;

    assign count_d = count_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_EMPTY;
            pkt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            error_q    <= 1'b0;
        end else if (flush_i) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {deliv_tick, in_axon_i, in_debug_i};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != DEPTH_L);
            if (reject || stale_evt) begin
                error_q <= 1'b1;
            end
            case (state_q)
                S_EMPTY: begin
                    if (head_load) begin
                        pkt_q   <= head;
                        state_q <= S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (fire) begin
                        if (head_load) begin
                            pkt_q <= head;
                        end else begin
                            state_q <= S_EMPTY;
                        end
                    end else if (out_stale) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

`ifdef SPIKE_ROUTER_STATS_EN
    logic [CNT_W-1:0] reject_cnt_q, stale_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reject_cnt_q <= '0;
            stale_cnt_q  <= '0;
        end else begin
            if (reject && (reject_cnt_q != '1)) begin
                reject_cnt_q <= reject_cnt_q + CNT_W'(1);
            end
            if (stale_evt && (stale_cnt_q != '1)) begin
                stale_cnt_q <= stale_cnt_q + CNT_W'(1);
            end
        end
    end

    assign reject_count_o = reject_cnt_q;
    assign stale_count_o  = stale_cnt_q;
`else
    assign reject_count_o = '0;
    assign stale_count_o  = '0;
`endif

    assign in_ready_o           = in_ready_q;
    assign spike_packet_o       = pkt_q;
    assign spike_packet_valid_o = (state_q == S_LOADED);
    assign fifo_level_o         = count_q;
    assign error_o              = error_q;

endmodule

// File: tb/tb_spike_packet_router.sv
module tb_spike_packet_router;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_axon_i;
    logic [3:0]  in_delay_i;
    logic [1:0]  in_debug_i;
    logic [3:0]  current_tick_i;
    logic        flush_i;
    logic [13:0] spike_packet_o;
    logic        spike_packet_valid_o;
    logic        spike_packet_ready_i;
    logic [3:0]  fifo_level_o;
    logic [7:0]  reject_count_o;
    logic [7:0]  stale_count_o;
    logic        error_o;

    spike_packet_router dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .in_valid_i           (in_valid_i),
        .in_ready_o           (in_ready_o),
        .in_axon_i            (in_axon_i),
        .in_delay_i           (in_delay_i),
        .in_debug_i           (in_debug_i),
        .current_tick_i       (current_tick_i),
        .flush_i              (flush_i),
        .spike_packet_o       (spike_packet_o),
        .spike_packet_valid_o (spike_packet_valid_o),
        .spike_packet_ready_i (spike_packet_ready_i),
        .fifo_level_o         (fifo_level_o),
        .reject_count_o       (reject_count_o),
        .stale_count_o        (stale_count_o),
        .error_o              (error_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int rej_n = 0;
    int stale_n = 0;
    logic [13:0] exp_q [$];

    // Expected counter value: saturating count when statistics are built in,
    // constant zero otherwise.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef SPIKE_ROUTER_STATS_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [13:0] mk_pkt(input int tick, input int axon, input int dbg);
        logic [3:0] t;
        logic [7:0] a;
        logic [1:0] d;
        t = 4'(tick % 16);
        a = 8'(axon);
        d = 2'(dbg);
        return {t, a, d};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input int axon, input int delay, input int dbg);
        in_valid_i = 1'b1;
        in_axon_i  = 8'(axon);
        in_delay_i = 4'(delay);
        in_debug_i = 2'(dbg);
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; in_axon_i = '0; in_delay_i = '0;
        in_debug_i = '0; current_tick_i = '0; flush_i = 1'b0; spike_packet_ready_i = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready_o, 0);
        check("rst_valid", spike_packet_valid_o, 0);
        check("rst_packet", spike_packet_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_reject", reject_count_o, 0);
        check("rst_stale", stale_count_o, 0);
        check("rst_error", error_o, 0);
        rst_i = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready_o, 1);

        // basic path: tick 3 + delay 2 -> tick 5
        current_tick_i = 4'd3;
        push_one(8'h2A, 2, 1);
        check("basic_valid_lat0", spike_packet_valid_o, 0);
        check("basic_level", fifo_level_o, 1);
        tick();
        check("basic_valid", spike_packet_valid_o, 1);
        check("basic_packet", spike_packet_o, mk_pkt(5, 8'h2A, 1));
        tick(); tick();
        check("basic_hold_valid", spike_packet_valid_o, 1);
        check("basic_hold_packet", spike_packet_o, mk_pkt(5, 8'h2A, 1));
        spike_packet_ready_i = 1'b1;
        tick();
        spike_packet_ready_i = 1'b0;
        check("basic_after_take", spike_packet_valid_o, 0);

        // wrap: 14 + 3 -> 1
        current_tick_i = 4'd14;
        push_one(8'h55, 3, 2);
        tick();
        check("wrap_valid", spike_packet_valid_o, 1);
        check("wrap_packet", spike_packet_o, mk_pkt(1, 8'h55, 2));
        spike_packet_ready_i = 1'b1;
        tick();
        spike_packet_ready_i = 1'b0;

        // reject
        current_tick_i = 4'd3;
        push_one(8'h11, 0, 0);
        rej_n++;
        check("reject_level", fifo_level_o, 0);
        check("reject_error", error_o, 1);
        check("reject_count", reject_count_o, exp_cnt(rej_n));
        tick();
        check("reject_no_valid", spike_packet_valid_o, 0);

        // backpressure: 8 pushes fill 7 FIFO entries plus the output stage
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            in_axon_i  = 8'(8'h40 + i);
            in_delay_i = 4'(i + 1);
            in_debug_i = 2'(i);
            exp_q.push_back(mk_pkt(3 + i + 1, 8'h40 + i, i));
            tick();
        end
        in_valid_i = 1'b0;
        check("bp_level7", fifo_level_o, 7);
        check("bp_valid", spike_packet_valid_o, 1);
        check("bp_ready_before9", in_ready_o, 1);
        exp_q.push_back(mk_pkt(12, 8'h48, 0));
        push_one(8'h48, 9, 0);
        check("bp_level8", fifo_level_o, 8);
        check("bp_ready_full", in_ready_o, 0);
        push_one(8'h49, 10, 1);
        check("bp_level_tenth", fifo_level_o, 8);
        check("bp_ready_tenth", in_ready_o, 0);
        spike_packet_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp_drain_valid%0d", i), spike_packet_valid_o, 1);
            check($sformatf("bp_drain_pkt%0d", i), spike_packet_o, exp_q[i]);
            tick();
        end
        spike_packet_ready_i = 1'b0;
        check("bp_drained_valid", spike_packet_valid_o, 0);
        check("bp_drained_level", fifo_level_o, 0);

        // stale held packet
        current_tick_i = 4'd3;
        push_one(8'h60, 1, 0);
        push_one(8'h61, 5, 1);
        check("stale_loaded", spike_packet_o, mk_pkt(4, 8'h60, 0));
        check("stale_level_pre", fifo_level_o, 1);
        current_tick_i = 4'd4;
        tick();
        stale_n++;
        check("stale_valid_drop", spike_packet_valid_o, 0);
        check("stale_count", stale_count_o, exp_cnt(stale_n));
        check("stale_level_post", fifo_level_o, 1);
        tick();
        check("stale_next_valid", spike_packet_valid_o, 1);
        check("stale_next_pkt", spike_packet_o, mk_pkt(8, 8'h61, 1));
        spike_packet_ready_i = 1'b1;
        tick();
        spike_packet_ready_i = 1'b0;

        // flush with a concurrent accept
        current_tick_i = 4'd3;
        for (int i = 0; i < 6; i++) begin
            push_one(8'h70 + i, i + 1, 0);
        end
        check("flush_level_pre", fifo_level_o, 5);
        flush_i = 1'b1;
        in_valid_i = 1'b1; in_axon_i = 8'h77; in_delay_i = 4'd2; in_debug_i = 2'd0;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_level", fifo_level_o, 0);
        check("flush_valid", spike_packet_valid_o, 0);
        check("flush_in_ready", in_ready_o, 1);
        tick(); tick(); tick();
        check("flush_no_more", spike_packet_valid_o, 0);
        check("flush_level_late", fifo_level_o, 0);
        check("flush_reject", reject_count_o, exp_cnt(rej_n));
        check("flush_stale", stale_count_o, exp_cnt(stale_n));
        check("flush_error", error_o, 1);

        // random traffic at a fixed tick: only delay 0 can be dropped
        current_tick_i = 4'($urandom_range(0, 15));
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid_i = ($urandom_range(0, 2) != 0);
            in_axon_i  = 8'($urandom);
            in_delay_i = 4'($urandom_range(0, 15));
            in_debug_i = 2'($urandom);
            spike_packet_ready_i = ($urandom_range(0, 3) != 0);
            if (spike_packet_valid_o && spike_packet_ready_i)
                check("rand_pkt", spike_packet_o,
                      (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
            if (in_valid_i && in_ready_o) begin
                if (in_delay_i >= 4'd1)
                    exp_q.push_back(mk_pkt(int'(current_tick_i) + int'(in_delay_i),
                                           in_axon_i, in_debug_i));
                else
                    rej_n++;
            end
            tick();
        end
        in_valid_i = 1'b0;
        spike_packet_ready_i = 1'b1;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || spike_packet_valid_o); c++) begin
            if (spike_packet_valid_o)
                check("rand_drain_pkt", spike_packet_o,
                      (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
            tick();
        end
        spike_packet_ready_i = 1'b0;
        check("rand_all_delivered", exp_q.size(), 0);
        check("rand_valid_end", spike_packet_valid_o, 0);
        check("rand_level_end", fifo_level_o, 0);
        check("rand_reject", reject_count_o, exp_cnt(rej_n));
        check("rand_stale", stale_count_o, exp_cnt(stale_n));

        // saturation of the reject counter
        in_valid_i = 1'b1; in_delay_i = 4'd0;
        for (int c = 0; c < 260; c++) begin
            in_axon_i = 8'($urandom);
            tick();
        end
        rej_n += 260;
        in_valid_i = 1'b0;
        tick();
        check("sat_reject", reject_count_o, exp_cnt(rej_n));
        check("sat_level", fifo_level_o, 0);
        check("sat_error", error_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
